// File: rtl/variable_argument_decoder_if.sv
// Stream-buffer bus between the producer/consumer side and the
// variable-argument decoder: push/pop controls in, peek window and
// occupancy flags out.
interface variable_argument_decoder_if #(
    parameter int WIDTH_OUT    = 8,
    parameter int WIDTH_IN     = 8,
    parameter int BUFFER_WIDTH = 32
);
    localparam int PLW  = $clog2(WIDTH_IN) + 1;
    localparam int POPW = $clog2(WIDTH_OUT) + 1;
    localparam int LW   = $clog2(BUFFER_WIDTH) + 1;

    // producer side
    logic                 push;
    logic [PLW-1:0]       push_len;
    logic [WIDTH_IN-1:0]  d;

    // consumer side
    logic [POPW-1:0]      pop;
    logic                 align;
    logic [WIDTH_OUT-1:0] q;

    // status
    logic [LW-1:0]        level;
    logic                 full;
    logic                 almost_full;
    logic                 half_full;
    logic                 ready;
    logic                 error;

    // user of the buffer: drives push/pop/align, observes window and flags
    modport master (
        output push, push_len, d, pop, align,
        input  q, level, full, almost_full, half_full, ready, error
    );

    // the buffer itself
    modport slave (
        input  push, push_len, d, pop, align,
        output q, level, full, almost_full, half_full, ready, error
    );
endinterface

// File: rtl/variable_argument_decoder.sv
// Bit-granular stream buffer. Each edge applies, in order: a pop of
// 0..WIDTH_OUT bits, an optional discard up to the next ALIGN boundary of
// the consumed stream, then an append of 0..WIDTH_IN bits. Bit 0 of the
// storage is always the next bit to be consumed; bits at or above the
// current level are kept at zero so the peek window is zero-padded.
module variable_argument_decoder #(
    parameter int WIDTH_OUT    = 8,
    parameter int WIDTH_IN     = 8,
    parameter int BUFFER_WIDTH = 32,
    parameter int ALIGN        = 8
) (
    input logic                        clk,
    input logic                        rst,
    variable_argument_decoder_if.slave bus
);
    localparam int LW  = $clog2(BUFFER_WIDTH) + 1;
    localparam int PLW = $clog2(WIDTH_IN) + 1;
    localparam int SW  = LW + 1;
    localparam int CW  = (ALIGN > 1) ? $clog2(ALIGN) : 1;

    localparam logic [CW-1:0] CONS_MASK  = CW'(ALIGN - 1);
    localparam logic [LW-1:0] FULL_LIM   = LW'(BUFFER_WIDTH - WIDTH_IN);
    localparam int            AF_LIM     = BUFFER_WIDTH - 2 * WIDTH_IN;
    localparam logic [LW-1:0] HALF_LEVEL = LW'(BUFFER_WIDTH / 2);
    localparam logic [LW-1:0] READY_LVL  = LW'(WIDTH_OUT);

    // registered state
    logic [BUFFER_WIDTH-1:0] store_q;
    logic [LW-1:0]           level_q;
    logic [CW-1:0]           cons_q;
    logic                    error_q;

    // pop stage
    logic                    pop_ok;
    logic [BUFFER_WIDTH-1:0] store_pop;
    logic [LW-1:0]           level_pop;
    logic [CW-1:0]           cons_pop;

    // align stage
    logic [CW-1:0]           align_r;
    logic [BUFFER_WIDTH-1:0] store_align;
    logic [LW-1:0]           level_align;
    logic [CW-1:0]           cons_align;

    // push stage
    logic                    push_ok;
    logic [WIDTH_IN-1:0]     len_mask;
    logic [BUFFER_WIDTH-1:0] push_bits;
    logic [BUFFER_WIDTH-1:0] store_d;
    logic [LW-1:0]           level_d;
    logic                    error_d;

    // Pop: accepted only when enough bits are held; otherwise the buffer is untouched.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        store_pop = store_q;
        level_pop = level_q;
        cons_pop  = cons_q;
        pop_ok    = (LW'(bus.pop) <= level_q);
        if (pop_ok) begin
            store_pop = store_q >> bus.pop;
            level_pop = level_q - LW'(bus.pop);
            cons_pop  = (cons_q + CW'(bus.pop)) & CONS_MASK;
        end
    end

    // Align: drop bits up to the next ALIGN boundary, or everything held if that is fewer.
    always_comb begin
        store_align = store_pop;
        level_align = level_pop;
        cons_align  = cons_pop;
        align_r     = (CW'(0) - cons_pop) & CONS_MASK;
        if (bus.align) begin
            if (LW'(align_r) > level_pop) begin
                store_align = '0;
                level_align = '0;
            end else begin
                store_align = store_pop >> align_r;
                level_align = level_pop - LW'(align_r);
            end
            // Either branch leaves the consumed stream on a boundary.
            cons_align = '0;
        end
    end

    // Push: append masked data above the surviving bits, all-or-nothing.
    always_comb begin
        store_d   = store_align;
        level_d   = level_align;
        push_ok   = ((SW'(level_align) + SW'(bus.push_len)) <= SW'(BUFFER_WIDTH))
                    && (bus.push_len <= PLW'(WIDTH_IN));
        len_mask  = ~({WIDTH_IN{1'b1}} << bus.push_len);
        push_bits = BUFFER_WIDTH'(bus.d & len_mask) << level_align;
        if (bus.push && push_ok) begin
            store_d = store_align | push_bits;
            level_d = level_align + LW'(bus.push_len);
        end
        error_d = error_q | ~pop_ok | (bus.push & ~push_ok);
    end

    // State update; reset clears the whole storage so stale bits never reach the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage is reset too, because the zero-above-level invariant depends on it.
            store_q <= '0;
            level_q <= '0;
            cons_q  <= '0;
            error_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            store_q <= store_d;
            level_q <= level_d;
            cons_q  <= cons_align;
            error_q <= error_d;
        end
    end

    // Outputs derived from registered state only.
    assign bus.q           = store_q[WIDTH_OUT-1:0];
    assign bus.level       = level_q;
    assign bus.full        = (level_q > FULL_LIM);
    assign bus.almost_full = (int'(level_q) > AF_LIM);
    assign bus.half_full   = (level_q >= HALF_LEVEL);
    assign bus.ready       = (level_q >= READY_LVL);
    assign bus.error       = error_q;
endmodule

// File: doc/variable_argument_decoder.md
Name: variable_argument_decoder

Overview:
- Parametrised successor to the fixed-push argument decoder: a bit-granular stream buffer.
- Each push appends a variable number of bits, 1..WIDTH_IN.
- The consumer peeks a WIDTH_OUT-bit window and pops 0..WIDTH_OUT bits per cycle.
- Adds alignment-discard, sticky overflow/underflow error and a level output. Sits between the word-oriented input FIFO and argument-field parsers.

Parameters:
- WIDTH_OUT, 8, peek window width and maximum pop size in bits.
- WIDTH_IN, 8, maximum bits appended per push.
- BUFFER_WIDTH, 32, storage capacity in bits; must be >= WIDTH_IN+WIDTH_OUT and even.
- ALIGN, 8, alignment granule in bits for the align operation; power of two, <= BUFFER_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  append request.
- push_len  input  clog2(WIDTH_IN)+1  number of valid bits in d (LSBs); 0 means no-op.
- d  input  WIDTH_IN  push data; bit 0 is consumed first.
- q  output  WIDTH_OUT  buffer bits [WIDTH_OUT-1:0]; bit 0 is the next bit to consume.
- level  output  clog2(BUFFER_WIDTH)+1  bits currently held.
- full  output  1  free space < WIDTH_IN.
- almost_full  output  1  free space < 2*WIDTH_IN.
- half_full  output  1  level >= BUFFER_WIDTH/2.
- ready  output  1  level >= WIDTH_OUT.
- pop  input  clog2(WIDTH_OUT)+1  bits to consume this cycle; 0 means none.
- align  input  1  discard bits up to the next ALIGN boundary of the consumed stream.
- error  output  1  sticky; set on rejected push or pop; cleared only by reset.

Behaviour:
- Reset (rst low): asynchronous, takes effect without a clock edge.
  - Buffer, level, consumed-bit counter and error go to 0; q=0, ready=0, full=0, almost_full=0, half_full=0.
  - Reset mid-operation discards all contents.
- All outputs are registered or derived combinationally from registered state. q reflects pushes and pops one cycle after the edge that applied them.
- Bits above level in the buffer are always 0, so q is zero-padded when level < WIDTH_OUT.
- Per-edge order: pop, then align, then push.
  - Pop: legal iff pop <= level. If legal, shift right by pop, level -= pop, consumed counter (mod ALIGN) += pop. If illegal, ignore the pop and set error.
  - Align: discard r = (ALIGN - consumed mod ALIGN) mod ALIGN bits, where consumed is the value after the pop step.
    - If r > level, discard level bits instead, set consumed mod ALIGN to 0, and do not set error.
    - Align with r=0 is a no-op.
  - Push: legal iff level_after_pop_align + push_len <= BUFFER_WIDTH and push_len <= WIDTH_IN.
    - If legal, write d[push_len-1:0] at bit position level_after_pop_align and add push_len to level.
    - If illegal, ignore the push entirely (no partial write) and set error.
    - Bits of d above push_len are ignored.
- Simultaneous push and pop are always evaluated with pop first. A push into a buffer that is full but being popped this cycle is therefore accepted when space suffices after the pop.
- Flags are computed from the new level:
  - full = BUFFER_WIDTH - level < WIDTH_IN
  - almost_full = BUFFER_WIDTH - level < 2*WIDTH_IN
  - half_full = level >= BUFFER_WIDTH/2
  - ready = level >= WIDTH_OUT
- The consumed counter is clog2(ALIGN) bits and wraps freely; only its value mod ALIGN is meaningful.
- There is no state machine beyond level and consumed; all operations are single-cycle with no stall.

Test Plan (defaults WIDTH_OUT=8, WIDTH_IN=8, BUFFER_WIDTH=32, ALIGN=8):
- Reset then basic peek and pop.
  - Stimulus: hold rst low, release; push d=0xAB, push_len=8.
  - Required: next cycle q=0xAB, level=8, ready=1.
  - Stimulus: pop=4.
  - Required: next cycle q=0x0A, level=4, ready=0.
- Variable push then align.
  - Stimulus: from level=4, q=0x0A, push d=0x05, push_len=3.
  - Required: q=0x5A, level=7.
  - Stimulus: align=1.
  - Required: 4 bits dropped, level=3, q=0x05.
- Fill and overflow.
  - Stimulus: from empty, push 0xFF with push_len=8 four times.
  - Required flag sequence:
    - half_full=1 at level 16.
    - almost_full=1 at level 24.
    - full=1 at level 32.
  - Stimulus: fifth push.
  - Required: rejected, level=32, error=1.
- Underflow.
  - Stimulus: level=3, pop=4.
  - Required: pop ignored, level=3, q unchanged, error=1.
- Simultaneous push and pop.
  - Stimulus: level=8, q=0xAB; push 0xCD with push_len=8 and pop=8 on the same edge.
  - Required: level=8, q=0xCD, error=0.
  - Stimulus: at level=32, push_len=8 with pop=8.
  - Required: accepted, level=32.
- Asynchronous reset mid-stream.
  - Stimulus: level=20; drive rst low between clock edges.
  - Required: level=0, q=0, all flags 0 and error=0 before the next rising edge.
